// File: rtl/rr_output_sched.sv
// Credit-based round-robin scheduler for one router output port: pops one of
// four input-buffer heads per cycle and registers it onto the output link.
module rr_output_sched #(
  parameter int unsigned CREDITS  = 4,
  parameter type         packet_t = logic [31:0],
  localparam int unsigned CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [3:0]    buf_empty,
  input  packet_t       buf_data [4],
  output logic [3:0]    buf_rd_en,
  input  logic          credit_ret,
  output packet_t       out_pkt,
  output logic          out_valid,
  output logic [CW-1:0] credit_cnt,
  output logic [1:0]    last_grant,
  output logic          cred_err
);

  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  logic       found;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       go;

  // Search starts one past the previous winner; k=4 wraps back to last_grant itself.
  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    idx    = last_grant;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last_grant + k[1:0];
      if (!found && !buf_empty[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // rst_n gating keeps the pop strobes quiet while the block is held in reset.
  assign go = rst_n && en && (credit_cnt != '0) && found;

  always_comb begin
    buf_rd_en = '0;
    if (go) buf_rd_en[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pkt    <= '0;
      out_valid  <= 1'b0;
      last_grant <= 2'd3;
    end else if (go) begin
      out_pkt    <= buf_data[winner];
      out_valid  <= 1'b1;
      last_grant <= winner;
    end else begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt <= CRED_MAX;
      cred_err   <= 1'b0;
    end else if (go && !credit_ret) begin
      credit_cnt <= credit_cnt - CW'(1);
    end else if (!go && credit_ret) begin
      if (credit_cnt == CRED_MAX) cred_err <= 1'b1;
      else                        credit_cnt <= credit_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_rr_output_sched.sv
// Randomized and directed checks of rr_output_sched against a queue-based
// reference model; output packets are matched by an independent monitor.
module tb_rr_output_sched;

  localparam int unsigned CREDITS = 4;
  localparam int unsigned CW      = $clog2(CREDITS + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [3:0]    buf_empty;
  logic [31:0]   buf_data [4];
  logic [3:0]    buf_rd_en;
  logic          credit_ret;
  logic [31:0]   out_pkt;
  logic          out_valid;
  logic [CW-1:0] credit_cnt;
  logic [1:0]    last_grant;
  logic          cred_err;

  rr_output_sched #(.CREDITS(CREDITS), .packet_t(logic [31:0])) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .buf_empty(buf_empty), .buf_data(buf_data),
    .buf_rd_en(buf_rd_en), .credit_ret(credit_ret), .out_pkt(out_pkt),
    .out_valid(out_valid), .credit_cnt(credit_cnt), .last_grant(last_grant),
    .cred_err(cred_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];

  // reference model state
  int  m_cnt;
  int  m_lg;
  bit  m_err;
  int  grants_seen [$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every pushed expectation must appear on the link on the next edge.
  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("out_pkt", out_pkt, exp_q.pop_front());
      end
    end else if (exp_q.size() != 0) begin
      chk("missing_out_valid", 0, exp_q.size());
      exp_q.delete();
    end
  end

  task automatic model_reset();
    m_cnt = CREDITS;
    m_lg  = 3;
    m_err = 0;
  endtask

  // Drive one cycle of stimulus, check the combinational grant and the
  // registered state against the model, then advance the model.
  task automatic cycle(input bit e, input logic [3:0] emp, input bit cr);
    int  win;
    bit  go;
    logic [3:0] exp_rd;
    @(posedge clk);
    #2;
    en = e;
    buf_empty = emp;
    credit_ret = cr;
    for (int i = 0; i < 4; i++) buf_data[i] = $urandom;
    #3;
    chk("credit_cnt", credit_cnt, m_cnt);
    chk("last_grant", last_grant, m_lg);
    chk("cred_err", cred_err, m_err);
    win = -1;
    for (int k = 1; k <= 4; k++) begin
      int p;
      p = (m_lg + k) % 4;
      if (win < 0 && !emp[p]) win = p;
    end
    go = e && (m_cnt > 0) && (win >= 0);
    exp_rd = go ? 4'(1 << win) : 4'b0;
    chk("buf_rd_en", buf_rd_en, exp_rd);
    if (go) begin
      exp_q.push_back(buf_data[win]);
      grants_seen.push_back(win);
      m_lg = win;
    end
    if (go && !cr) m_cnt--;
    else if (!go && cr) begin
      if (m_cnt == CREDITS) m_err = 1;
      else m_cnt++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    en = 1'b1;
    buf_empty = 4'b0000;
    credit_ret = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pkt", out_pkt, 0);
    chk("rst_credit_cnt", credit_cnt, CREDITS);
    chk("rst_last_grant", last_grant, 3);
    chk("rst_cred_err", cred_err, 0);
    chk("rst_buf_rd_en", buf_rd_en, 0);
    #1;
    en = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    buf_empty = 4'hF;
    credit_ret = 1'b0;
    for (int i = 0; i < 4; i++) buf_data[i] = '0;
    model_reset();
    #12;
    do_reset();

    // all ports busy, credit continuously returned: strict rotation
    grants_seen.delete();
    repeat (6) cycle(1, 4'b0000, 1);
    for (int i = 0; i < 6; i++) chk("rotation", grants_seen[i], i % 4);

    // single port drains the credits
    do_reset();
    grants_seen.delete();
    repeat (6) cycle(1, 4'b1011, 0);
    chk("port2_grants", grants_seen.size(), 4);
    chk("credit_zero", credit_cnt, 0);

    // credit return at zero credits: no grant that cycle, exactly one after
    grants_seen.delete();
    cycle(1, 4'b1011, 1);
    repeat (3) cycle(1, 4'b1011, 0);
    chk("one_grant_after_ret", grants_seen.size(), 1);

    // simultaneous grant and return at credit 2
    do_reset();
    cycle(1, 4'b1110, 0);
    cycle(1, 4'b1110, 0);
    cycle(1, 4'b1110, 1);
    cycle(0, 4'b1111, 0);
    chk("cnt_hold_2", credit_cnt, 2);

    // return while full sets sticky error
    do_reset();
    cycle(1, 4'b1111, 1);
    repeat (3) cycle(1, 4'b1111, 0);
    chk("cred_err_sticky", cred_err, 1);
    chk("cnt_full", credit_cnt, CREDITS);

    // last grant 1, ports 0 and 3 pending: 3 then 0; then en dropped
    do_reset();
    cycle(1, 4'b1101, 1);
    grants_seen.delete();
    cycle(1, 4'b0110, 1);
    cycle(1, 4'b0110, 1);
    chk("lg1_first", grants_seen[0], 3);
    chk("lg1_second", grants_seen[1], 0);
    cycle(0, 4'b0110, 1);
    cycle(0, 4'b0000, 0);

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle($urandom_range(0, 9) != 0, 4'($urandom),
            $urandom_range(0, 2) == 0);
    end
    cycle(0, 4'b1111, 0);
    cycle(0, 4'b1111, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
